ws2812_rx: RTL and testbench

- Receive-side counterpart of the WS2812 bit controller: decodes a single-wire WS2812 NZR stream into 24-bit GRB pixel words.
- Consumes the same waveform the transmit chain drives onto the LED strip.
- Used for loopback self-test of the transmit path and for capturing upstream strip data into the 64-entry layer RAM.
- Output is one pixel word per 24 decoded bits, plus a frame-end strobe on the reset code.

---
 rtl/ws2812_rx.sv | 171 +++++++++++++++++
 tb/tb_ws2812_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 NZR serial line into 24-bit GRB pixel words plus a frame-end strobe.
// Defining WS2812_RX_ERR_EN enables high-pulse width checking and the err_out strobe.
module ws2812_rx #(
  parameter int unsigned BIT_THRES = 60,
  parameter int unsigned RST_CNT   = 5000,
  parameter int unsigned MIN_HIGH  = 15,
  parameter int unsigned MAX_HIGH  = 150
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        din_in,
  output logic        pixel_vld_out,
  output logic [23:0] pixel_data_out,
  output logic [5:0]  pixel_idx_out,
  output logic        frame_done_out,
  output logic        err_out
);

  localparam logic [15:0] THRES_W = 16'(BIT_THRES);
  localparam logic [15:0] RST_W   = 16'(RST_CNT);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Counters are 16 bits and saturate, so every threshold has to fit below the ceiling.
  if (BIT_THRES == 0 || RST_CNT == 0 || RST_CNT >= 65535 ||
      MIN_HIGH > MAX_HIGH || MAX_HIGH >= 65535) begin : g_bad_cfg
    $error("ws2812_rx: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  sync_r;
  logic        din_d_r;
  logic [15:0] high_cnt_r;
  logic [15:0] low_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [22:0] shreg_r;
  logic [5:0]  idx_r;

  logic din_s;
  logic rise_s;
  logic fall_s;
  logic bit_s;
  logic len_bad_s;
  logic stuck_s;

  // Two-flop synchronizer for the asynchronous line plus a delayed copy for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_r  <= 2'b00;
      din_d_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], din_in};
      din_d_r <= sync_r[1];
    end
  end

  // Edge detection, bit decision and (optional) pulse-width qualification.
  always_comb begin
    din_s  = sync_r[1];
    rise_s = din_s & ~din_d_r;
    fall_s = ~din_s & din_d_r;
    bit_s  = (high_cnt_r >= THRES_W);
`ifdef WS2812_RX_ERR_EN
    len_bad_s = (high_cnt_r < 16'(MIN_HIGH)) || (high_cnt_r > 16'(MAX_HIGH));
    stuck_s   = din_s && (high_cnt_r > 16'(MAX_HIGH));
`else
    len_bad_s = 1'b0;
    stuck_s   = 1'b0;
`endif
  end

  // Run-length counters; the edge cycle loads 1 so the count at the opposite edge equals the level length.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      high_cnt_r <= 16'd0;
      low_cnt_r  <= 16'd0;
    end else begin
      if (rise_s) begin
        high_cnt_r <= 16'd1;
      end else if (din_s && (high_cnt_r != CNT_MAX)) begin
        high_cnt_r <= high_cnt_r + 16'd1;
      end else begin
        high_cnt_r <= high_cnt_r;
      end
      if (fall_s) begin
        low_cnt_r <= 16'd1;
      end else if (!din_s && (low_cnt_r != CNT_MAX)) begin
        low_cnt_r <= low_cnt_r + 16'd1;
      end else begin
        low_cnt_r <= low_cnt_r;
      end
    end
  end

  // Decoder FSM with registered pixel, frame and error strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r        <= ST_SYNC;
      bit_cnt_r      <= 5'd0;
      shreg_r        <= 23'd0;
      idx_r          <= 6'd0;
      pixel_vld_out  <= 1'b0;
      pixel_data_out <= 24'd0;
      pixel_idx_out  <= 6'd0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      pixel_vld_out  <= 1'b0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
      case (state_r)
        // A rise only counts as the end of the reset low when it is the edge itself, not a long high.
        ST_SYNC: begin
          if ((low_cnt_r >= RST_W) && (!din_s || rise_s)) begin
            state_r <= rise_s ? ST_HIGH : ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall_s && len_bad_s) begin
            err_out   <= 1'b1;
            bit_cnt_r <= 5'd0;
            idx_r     <= 6'd0;
            state_r   <= ST_SYNC;
          end else if (fall_s) begin
            state_r <= ST_LOW;
            if (bit_cnt_r == 5'd23) begin
              pixel_data_out <= {shreg_r, bit_s};
              pixel_idx_out  <= idx_r;
              pixel_vld_out  <= 1'b1;
              idx_r          <= idx_r + 6'd1;
              bit_cnt_r      <= 5'd0;
            end else begin
              shreg_r   <= {shreg_r[21:0], bit_s};
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end else if (stuck_s) begin
            err_out   <= 1'b1;
            bit_cnt_r <= 5'd0;
            idx_r     <= 6'd0;
            state_r   <= ST_SYNC;
          end
        end
        ST_LOW: begin
          if (low_cnt_r >= RST_W) begin
            frame_done_out <= 1'b1;
            idx_r          <= 6'd0;
            bit_cnt_r      <= 5'd0;
            state_r        <= rise_s ? ST_HIGH : ST_IDLE;
          end else if (rise_s) begin
            state_r <= ST_HIGH;
          end
        end
        default: begin
          state_r <= ST_SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized NZR waveforms checked against a pulse-width level model of the decoder.
module tb_ws2812_rx;

  localparam int RST  = 1000;
  localparam int TH   = 60;
  localparam int MINH = 15;
  localparam int MAXH = 150;
  localparam int GAP  = 1200;
`ifdef WS2812_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        pixel_vld_out;
  logic [23:0] pixel_data_out;
  logic [5:0]  pixel_idx_out;
  logic        frame_done_out;
  logic        err_out;

  ws2812_rx #(.BIT_THRES(TH), .RST_CNT(RST), .MIN_HIGH(MINH), .MAX_HIGH(MAXH)) dut (
    .clk_in(clk), .rst_in(rst), .din_in(din),
    .pixel_vld_out(pixel_vld_out), .pixel_data_out(pixel_data_out),
    .pixel_idx_out(pixel_idx_out), .frame_done_out(frame_done_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 1 pixel, 2 frame done, 3 error
    logic [23:0] data;
    logic [5:0]  idx;
    int unsigned at;
  } ev_t;

  ev_t exp_q[$];
  int total = 0, bad = 0;
  int pix_seen = 0, fd_seen = 0, err_seen = 0;
  logic [23:0] last_data = 24'd0;
  logic [5:0]  last_idx = 6'd0;

  bit m_synced = 1'b0, m_in_frame = 1'b0, m_hold = 1'b0;
  bit bitq[$];
  int m_idx = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: a bit is its high length vs threshold, 24 bits make a pixel, a long low ends a frame.
  task automatic model_bit(input int hi, input int lo, input int unsigned fall_at);
    ev_t e;
    if (m_hold) return;
    if (m_synced) begin
      if (ERR_EN && (hi < MINH || hi > MAXH)) begin
        e.kind = 3; e.data = 24'd0; e.idx = 6'd0; e.at = fall_at + 3;
        exp_q.push_back(e);
        m_synced = 1'b0; m_in_frame = 1'b0; bitq.delete(); m_idx = 0;
      end else begin
        m_in_frame = 1'b1;
        bitq.push_back(hi >= TH);
        if (bitq.size() == 24) begin
          e.kind = 1; e.data = 24'd0;
          foreach (bitq[i]) e.data = {e.data[22:0], bitq[i]};
          e.idx = 6'(m_idx); e.at = fall_at + 3;
          exp_q.push_back(e);
          m_idx = (m_idx + 1) % 64;
          bitq.delete();
        end
      end
    end
    if (lo >= RST) begin
      if (!m_synced) begin
        m_synced = 1'b1;
      end else if (m_in_frame) begin
        e.kind = 2; e.data = 24'd0; e.idx = 6'd0; e.at = fall_at + RST + 3;
        exp_q.push_back(e);
      end
      m_in_frame = 1'b0; bitq.delete(); m_idx = 0;
    end
  endtask

  task automatic bit_pulse(input int hi, input int lo);
    int unsigned f;
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    f = cyc;
    model_bit(hi, lo, f);
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] px, input int last_lo);
    int hi;
    for (int i = 23; i >= 0; i--) begin
      hi = px[i] ? 80 : 40;
      bit_pulse(hi, (i == 0) ? last_lo : 125 - hi);
    end
  endtask

  task automatic send_fast(input logic [23:0] px, input int last_lo);
    for (int i = 23; i >= 0; i--) begin
      bit_pulse(px[i] ? int'($urandom_range(64, 60)) : int'($urandom_range(20, 16)),
                (i == 0) ? last_lo : int'($urandom_range(5, 3)));
    end
  endtask

  task automatic take_event(input int kind);
    ev_t e;
    if (kind == 1) begin
      pix_seen++; last_data = pixel_data_out; last_idx = pixel_idx_out;
    end else if (kind == 2) begin
      fd_seen++;
    end else begin
      err_seen++;
    end
    if (exp_q.size() == 0) begin
      check_val("unexpected_evt", kind, 0);
      return;
    end
    e = exp_q.pop_front();
    check_val("evt_kind", kind, e.kind);
    check_val("evt_cycle", cyc, e.at);
    if (kind == 1 && e.kind == 1) begin
      check_val("pix_data", pixel_data_out, e.data);
      check_val("pix_idx", pixel_idx_out, e.idx);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_vld_out)  take_event(1);
      if (frame_done_out) take_event(2);
      if (err_out)        take_event(3);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int fd0, pix0, err0;
    logic [23:0] px;
    repeat (3) @(negedge clk);
    check_val("rst_vld", pixel_vld_out, 0);
    check_val("rst_data", pixel_data_out, 0);
    check_val("rst_idx", pixel_idx_out, 0);
    check_val("rst_done", frame_done_out, 0);
    check_val("rst_err", err_out, 0);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
    m_synced = 1'b1;

    send_pixel(24'hA53C0F, 45);
    check_val("t1_count", pix_seen, 1);
    check_val("t1_data", last_data, 24'hA53C0F);
    check_val("t1_idx", last_idx, 0);

    for (int p = 0; p < 64; p++)
      send_fast($urandom & $urandom & $urandom, (p == 63) ? GAP : int'($urandom_range(5, 3)));
    check_val("t2_pix", pix_seen, 65);
    check_val("t2_last_idx", last_idx, 0);
    check_val("t2_done", fd_seen, 1);
    check_val("t2_drain", exp_q.size(), 0);

    for (int i = 0; i < 10; i++)
      bit_pulse(int'($urandom_range(140, 16)), (i == 9) ? GAP : int'($urandom_range(60, 5)));
    check_val("t3_no_pix", pix_seen, 65);
    check_val("t3_done", fd_seen, 2);
    px = $urandom;
    send_fast(px, GAP);
    check_val("t3_next_data", last_data, px);
    check_val("t3_next_idx", last_idx, 0);

    rst = 1'b1; m_hold = 1'b1;
    bit_pulse(40, 85);
    bit_pulse(80, 45);
    check_val("t4_rst_data", pixel_data_out, 0);
    check_val("t4_rst_idx", pixel_idx_out, 0);
    rst = 1'b0; m_hold = 1'b0;
    m_synced = 1'b0; m_in_frame = 1'b0; bitq.delete(); m_idx = 0;
    fd0 = fd_seen; pix0 = pix_seen;
    for (int i = 0; i < 7; i++)
      bit_pulse(int'($urandom_range(140, 16)), (i == 6) ? GAP : 60);
    check_val("t4_sync_no_done", fd_seen, fd0);
    check_val("t4_sync_no_pix", pix_seen, pix0);
    px = $urandom;
    send_fast(px, GAP);
    check_val("t4_data", last_data, px);
    check_val("t4_idx", last_idx, 0);
    check_val("t4_done", fd_seen, fd0 + 1);

    for (int i = 23; i >= 0; i--)
      bit_pulse((i % 2 == 1) ? 60 : 59, (i == 0) ? GAP : 30);
    check_val("t5_thres", last_data, 24'hAAAAAA);

    pix0 = pix_seen; err0 = err_seen;
    for (int i = 23; i >= 0; i--)
      bit_pulse((i == 23) ? 10 : (($urandom_range(1, 0) == 1) ? 80 : 40), (i == 0) ? GAP : 40);
    if (ERR_EN) begin
      check_val("t6_err_once", err_seen, err0 + 1);
      check_val("t6_no_pix", pix_seen, pix0);
    end else begin
      check_val("t6_no_err", err_seen, err0);
      check_val("t6_msb_zero", last_data[23], 0);
    end
    px = $urandom;
    send_fast(px, GAP);
    check_val("t6_after_data", last_data, px);
    check_val("t6_after_idx", last_idx, 0);

    for (int i = 0; i < 48; i++)
      bit_pulse(int'($urandom_range(140, 16)), (i == 47) ? GAP : int'($urandom_range(40, 5)));
    check_val("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
